// File: rtl/mib_ctrl_pkg.sv
// mib_ctrl_pkg
//   Shared definitions for the MIB counter engine: default widths, the
//   default minimum busy time and the controller FSM state encoding.
package mib_ctrl_pkg;

  localparam int unsigned MIB_ADDR_WIDTH_DEF = 8;
  localparam int unsigned MIB_DATA_WIDTH_DEF = 32;
  localparam int unsigned MIB_INC_WIDTH_DEF  = 8;
  localparam int unsigned MIB_BUSY_MIN_DEF   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_H_RD_WAIT,
    ST_INC_RD_WAIT,
    ST_INC_WR,
    ST_BUSY_HOLD
  } mib_state_e;

endpackage

// File: rtl/mib_controller_inc_sat.sv
// mibIncSat
//   Combinational saturating adder used by the counter read-modify-write.
//   The increment is zero-extended and the sum is formed one bit wider than
//   the counter; a carry out clamps the result to all-ones.
// Ports:
//   acc_i  DATA_WIDTH  current counter value (RAM read data)
//   inc_i  INC_WIDTH   amount to add
//   sum_o  DATA_WIDTH  saturated sum
module mibIncSat #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned INC_WIDTH  = 8
) (
  input  logic [DATA_WIDTH-1:0] acc_i,
  input  logic [INC_WIDTH-1:0]  inc_i,
  output logic [DATA_WIDTH-1:0] sum_o
);

  logic [DATA_WIDTH:0] wide;

  always_comb begin
    wide  = {1'b0, acc_i} + {{(DATA_WIDTH + 1 - INC_WIDTH){1'b0}}, inc_i};
    sum_o = wide[DATA_WIDTH] ? '1 : wide[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/mib_controller.sv
// mib_controller
//   Core-clock MIB counter engine. Serialises single-cycle host read/write
//   pulses and MAC-core counter increments onto one single-port MIB RAM.
//   Host accesses are reported through mibBusy (its falling edge marks the
//   end of the access); increments are saturating read-modify-writes.
// Ports:
//   macCoreClk         clock
//   macCoreClkHardRst  synchronous active-high reset
//   mibAddr/mibWrData  host address / write data (stable around the pulse)
//   mibWr/mibRd        one-cycle host write/read pulses (write wins if both)
//   mibRdData          registered host read result
//   mibBusy            registered host-access-in-progress flag
//   mibIncReq          increment request level, held until mibIncAck
//   mibIncAddr/Value   counter address and increment amount
//   mibIncAck          one-cycle increment accept
//   ramCs/ramWe        RAM select / write enable (combinational from FSM)
//   ramAddr/ramWrData  RAM address / write data
//   ramRdData          RAM read data, valid the cycle after a read select
module mib_controller
  import mib_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = MIB_ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = MIB_DATA_WIDTH_DEF,
  parameter int unsigned INC_WIDTH  = MIB_INC_WIDTH_DEF,
  parameter int unsigned BUSY_MIN   = MIB_BUSY_MIN_DEF
) (
  input  logic                  macCoreClk,
  input  logic                  macCoreClkHardRst,
  input  logic [ADDR_WIDTH-1:0] mibAddr,
  input  logic [DATA_WIDTH-1:0] mibWrData,
  input  logic                  mibWr,
  input  logic                  mibRd,
  output logic [DATA_WIDTH-1:0] mibRdData,
  output logic                  mibBusy,
  input  logic                  mibIncReq,
  input  logic [ADDR_WIDTH-1:0] mibIncAddr,
  input  logic [INC_WIDTH-1:0]  mibIncValue,
  output logic                  mibIncAck,
  output logic                  ramCs,
  output logic                  ramWe,
  output logic [ADDR_WIDTH-1:0] ramAddr,
  output logic [DATA_WIDTH-1:0] ramWrData,
  input  logic [DATA_WIDTH-1:0] ramRdData
);

  localparam int unsigned CNT_W = (BUSY_MIN > 2) ? $clog2(BUSY_MIN) : 1;

  mib_state_e state_q, state_d;

  logic                  hostPend_q, hostPend_d;
  logic                  hostWr_q,   hostWr_d;
  logic [ADDR_WIDTH-1:0] hostAddr_q, hostAddr_d;
  logic [DATA_WIDTH-1:0] hostData_q, hostData_d;
  logic [ADDR_WIDTH-1:0] incAddr_q,  incAddr_d;
  logic [INC_WIDTH-1:0]  incVal_q,   incVal_d;
  logic [DATA_WIDTH-1:0] incRes_q,   incRes_d;
  logic [DATA_WIDTH-1:0] rdData_q,   rdData_d;
  logic                  busy_q,     busy_d;
  logic [CNT_W-1:0]      busyCnt_q,  busyCnt_d;

  logic                  hostCapture;
  logic [DATA_WIDTH-1:0] satSum;

  mibIncSat #(
    .DATA_WIDTH (DATA_WIDTH),
    .INC_WIDTH  (INC_WIDTH)
  ) u_inc_sat (
    .acc_i (ramRdData),
    .inc_i (incVal_q),
    .sum_o (satSum)
  );

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge macCoreClk) begin
    if (macCoreClkHardRst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state. Host work is preferred in IDLE; an increment, once
  // accepted, always runs to its write before IDLE is seen again.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (hostPend_q) begin
          state_d = hostWr_q ? ST_BUSY_HOLD : ST_H_RD_WAIT;
        end else if (mibIncReq) begin
          state_d = ST_INC_RD_WAIT;
        end
      end
      ST_H_RD_WAIT:   state_d = ST_BUSY_HOLD;
      ST_INC_RD_WAIT: state_d = ST_INC_WR;
      ST_INC_WR:      state_d = ST_IDLE;
      ST_BUSY_HOLD: begin
        if (busyCnt_q == '0) begin
          state_d = ST_IDLE;
        end
      end
      default:        state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs. Masked while reset is held so no RAM access or ack can
  // escape from the IDLE decode during reset.
  // ---------------------------------------------------------------------
  always_comb begin
    ramCs     = 1'b0;
    ramWe     = 1'b0;
    ramAddr   = '0;
    ramWrData = '0;
    mibIncAck = 1'b0;
    if (!macCoreClkHardRst) begin
      unique case (state_q)
        ST_IDLE: begin
          if (hostPend_q) begin
            ramCs     = 1'b1;
            ramWe     = hostWr_q;
            ramAddr   = hostAddr_q;
            ramWrData = hostData_q;
          end else if (mibIncReq) begin
            ramCs     = 1'b1;
            ramAddr   = mibIncAddr;
            mibIncAck = 1'b1;
          end
        end
        ST_INC_WR: begin
          ramCs     = 1'b1;
          ramWe     = 1'b1;
          ramAddr   = incAddr_q;
          ramWrData = incRes_q;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------
  assign hostCapture = (mibWr | mibRd) & ~hostPend_q;

  always_comb begin
    hostPend_d = hostPend_q;
    hostWr_d   = hostWr_q;
    hostAddr_d = hostAddr_q;
    hostData_d = hostData_q;
    incAddr_d  = incAddr_q;
    incVal_d   = incVal_q;
    incRes_d   = incRes_q;
    rdData_d   = rdData_q;
    busy_d     = busy_q;
    busyCnt_d  = busyCnt_q;

    if (busyCnt_q != '0) begin
      busyCnt_d = busyCnt_q - CNT_W'(1);
    end

    // Capture cannot coincide with release: release only happens while
    // hostPend is set, and capture requires it clear.
    if (hostCapture) begin
      hostPend_d = 1'b1;
      hostWr_d   = mibWr;
      hostAddr_d = mibAddr;
      hostData_d = mibWrData;
      busy_d     = 1'b1;
      busyCnt_d  = CNT_W'(BUSY_MIN - 1);
    end

    if (state_q == ST_BUSY_HOLD && busyCnt_q == '0) begin
      busy_d     = 1'b0;
      hostPend_d = 1'b0;
    end

    if (mibIncAck) begin
      incAddr_d = mibIncAddr;
      incVal_d  = mibIncValue;
    end

    if (state_q == ST_INC_RD_WAIT) begin
      incRes_d = satSum;
    end

    if (state_q == ST_H_RD_WAIT) begin
      rdData_d = ramRdData;
    end
  end

  always_ff @(posedge macCoreClk) begin
    if (macCoreClkHardRst) begin
      hostPend_q <= 1'b0;
      hostWr_q   <= 1'b0;
      hostAddr_q <= '0;
      hostData_q <= '0;
      incAddr_q  <= '0;
      incVal_q   <= '0;
      incRes_q   <= '0;
      rdData_q   <= '0;
      busy_q     <= 1'b0;
      busyCnt_q  <= '0;
    end else begin
      hostPend_q <= hostPend_d;
      hostWr_q   <= hostWr_d;
      hostAddr_q <= hostAddr_d;
      hostData_q <= hostData_d;
      incAddr_q  <= incAddr_d;
      incVal_q   <= incVal_d;
      incRes_q   <= incRes_d;
      rdData_q   <= rdData_d;
      busy_q     <= busy_d;
      busyCnt_q  <= busyCnt_d;
    end
  end

  assign mibRdData = rdData_q;
  assign mibBusy   = busy_q;

endmodule

// File: tb/tb_mib_controller.sv
// tb_mib_controller
//   Self-checking bench: a behavioural single-port RAM attached to the
//   controller, directed scenarios followed by randomised host/increment
//   traffic, all compared against a golden counter array.
module tb_mib_controller;

  localparam int BMIN = 4;
  localparam int RD_BUSY = ((BMIN + 1) > 4 ? (BMIN + 1) : 4) - 1;
  localparam int WR_BUSY = ((BMIN + 1) > 3 ? (BMIN + 1) : 3) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  mibAddr = '0;
  logic [31:0] mibWrData = '0;
  logic        mibWr = 1'b0;
  logic        mibRd = 1'b0;
  logic [31:0] mibRdData;
  logic        mibBusy;
  logic        mibIncReq = 1'b0;
  logic [7:0]  mibIncAddr = '0;
  logic [7:0]  mibIncValue = '0;
  logic        mibIncAck;
  logic        ramCs, ramWe;
  logic [7:0]  ramAddr;
  logic [31:0] ramWrData;
  logic [31:0] ramRdData = '0;

  always #5 clk = ~clk;

  mib_controller #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (32),
    .INC_WIDTH  (8),
    .BUSY_MIN   (BMIN)
  ) dut (
    .macCoreClk        (clk),
    .macCoreClkHardRst (rst),
    .mibAddr           (mibAddr),
    .mibWrData         (mibWrData),
    .mibWr             (mibWr),
    .mibRd             (mibRd),
    .mibRdData         (mibRdData),
    .mibBusy           (mibBusy),
    .mibIncReq         (mibIncReq),
    .mibIncAddr        (mibIncAddr),
    .mibIncValue       (mibIncValue),
    .mibIncAck         (mibIncAck),
    .ramCs             (ramCs),
    .ramWe             (ramWe),
    .ramAddr           (ramAddr),
    .ramWrData         (ramWrData),
    .ramRdData         (ramRdData)
  );

  // Behavioural single-port RAM, registered read.
  logic [31:0] mem [256] = '{default: '0};
  int          wr_count = 0;
  int          cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ramCs) begin
      if (ramWe) begin
        mem[ramAddr] <= ramWrData;
        wr_count     <= wr_count + 1;
      end else begin
        ramRdData <= mem[ramAddr];
      end
    end
  end

  // Golden model: what every counter should hold.
  logic [31:0] golden [256] = '{default: '0};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [7:0] v);
    longint s;
    s = longint'(a) + longint'(v);
    return (s > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Host access: pulse, then follow mibBusy until it falls. Returns the
  // number of busy-high cycles and mibRdData in the last busy-high cycle.
  task automatic host_access(input logic wr, input logic rd, input logic [7:0] a,
                             input logic [31:0] d, output int bcyc, output logic [31:0] rdv);
    mibAddr   = a;
    mibWrData = d;
    mibWr     = wr;
    mibRd     = rd;
    tick();
    mibWr = 1'b0;
    mibRd = 1'b0;
    bcyc  = 0;
    rdv   = mibRdData;
    while (mibBusy && bcyc < 64) begin
      rdv = mibRdData;
      bcyc++;
      tick();
    end
    check("busy_bounded", 32'(bcyc < 64), 32'd1);
  endtask

  // Increment: raise the request, wait (bounded) for the ack, return its cycle.
  task automatic do_inc(input logic [7:0] a, input logic [7:0] v, output int ackc);
    int k;
    mibIncReq   = 1'b1;
    mibIncAddr  = a;
    mibIncValue = v;
    k = 0;
    #1;
    while (!mibIncAck && k < 20) begin
      tick();
      #1;
      k++;
    end
    check("inc_ack_seen", 32'(mibIncAck), 32'd1);
    ackc = cyc;
    tick();
    mibIncReq = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int          bc, c0, c1, c2, w0, rdoff;
    logic [31:0] rdv;
    logic        seen;

    // ---------------- reset state ----------------
    repeat (3) tick();
    check("rst_busy", 32'(mibBusy), 32'd0);
    check("rst_rddata", mibRdData, 32'd0);
    check("rst_ack", 32'(mibIncAck), 32'd0);
    check("rst_cs", 32'(ramCs), 32'd0);
    check("rst_we", 32'(ramWe), 32'd0);
    rst = 1'b0;
    tick();

    // ---------------- host write then read ----------------
    w0 = wr_count;
    host_access(1'b1, 1'b0, 8'h10, 32'hDEAD_BEEF, bc, rdv);
    golden[8'h10] = 32'hDEAD_BEEF;
    check("wr_busy_len", 32'(bc), 32'(WR_BUSY));
    check("wr_one_ram_write", 32'(wr_count - w0), 32'd1);
    check("wr_mem", mem[8'h10], 32'hDEAD_BEEF);
    host_access(1'b0, 1'b1, 8'h10, 32'h0, bc, rdv);
    check("rd_busy_len", 32'(bc), 32'(RD_BUSY));
    check("rd_data_before_fall", rdv, 32'hDEAD_BEEF);

    // ---------------- three back-to-back increments ----------------
    do_inc(8'h03, 8'd5, c0);
    do_inc(8'h03, 8'd5, c1);
    do_inc(8'h03, 8'd5, c2);
    golden[8'h03] = 32'd15;
    check("ack_gap1", 32'(c1 - c0), 32'd3);
    check("ack_gap2", 32'(c2 - c1), 32'd3);
    repeat (2) tick();
    host_access(1'b0, 1'b1, 8'h03, 32'h0, bc, rdv);
    check("inc3_value", rdv, golden[8'h03]);

    // ---------------- saturation ----------------
    host_access(1'b1, 1'b0, 8'h07, 32'hFFFF_FFFE, bc, rdv);
    golden[8'h07] = 32'hFFFF_FFFE;
    do_inc(8'h07, 8'd4, c0);
    golden[8'h07] = sat_add(golden[8'h07], 8'd4);
    repeat (2) tick();
    host_access(1'b0, 1'b1, 8'h07, 32'h0, bc, rdv);
    check("sat_value", rdv, 32'hFFFF_FFFF);

    // ---------------- host read on the cycle of an increment ack ----------------
    mibIncReq   = 1'b1;
    mibIncAddr  = 8'h03;
    mibIncValue = 8'd2;
    mibAddr     = 8'h03;
    mibRd       = 1'b1;
    #1;
    check("conc_ack", 32'(mibIncAck), 32'd1);
    c0 = cyc;
    tick();
    mibIncReq = 1'b0;
    mibRd     = 1'b0;
    golden[8'h03] = sat_add(golden[8'h03], 8'd2);
    bc = 0; rdoff = -1; seen = 1'b0; rdv = '0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (ramCs && !ramWe && rdoff < 0) rdoff = cyc - c0;
      if (mibBusy) begin
        bc++;
        rdv  = mibRdData;
        seen = 1'b1;
      end else if (seen) begin
        break;
      end
      tick();
    end
    check("conc_rd_issue_offset", 32'(rdoff), 32'd3);
    check("conc_busy_continuous", 32'(bc), 32'(RD_BUSY + 1));
    check("conc_rd_data", rdv, golden[8'h03]);
    check("conc_mem", mem[8'h03], golden[8'h03]);
    tick();

    // ---------------- write and read together ----------------
    host_access(1'b1, 1'b1, 8'h20, 32'h0000_1234, bc, rdv);
    golden[8'h20] = 32'h0000_1234;
    check("wrrd_mem", mem[8'h20], 32'h0000_1234);
    check("wrrd_rddata_kept", mibRdData, golden[8'h03]);
    check("wrrd_busy_len", 32'(bc), 32'(WR_BUSY));

    // ---------------- reset during INC_RD_WAIT ----------------
    host_access(1'b1, 1'b0, 8'h05, 32'h0000_0100, bc, rdv);
    golden[8'h05] = 32'h0000_0100;
    mibIncReq   = 1'b1;
    mibIncAddr  = 8'h05;
    mibIncValue = 8'd9;
    #1;
    check("rstinc_ack", 32'(mibIncAck), 32'd1);
    tick();
    mibIncReq = 1'b0;
    w0  = wr_count;
    rst = 1'b1;
    tick();
    #1;
    check("rstinc_busy", 32'(mibBusy), 32'd0);
    check("rstinc_rddata", mibRdData, 32'd0);
    check("rstinc_ack0", 32'(mibIncAck), 32'd0);
    check("rstinc_cs", 32'(ramCs), 32'd0);
    check("rstinc_we", 32'(ramWe), 32'd0);
    rst = 1'b0;
    repeat (3) tick();
    check("rstinc_no_write", 32'(wr_count - w0), 32'd0);
    check("rstinc_mem", mem[8'h05], 32'h0000_0100);
    host_access(1'b0, 1'b1, 8'h05, 32'h0, bc, rdv);
    check("rstinc_rd_after", rdv, golden[8'h05]);
    check("rstinc_rd_busy", 32'(bc), 32'(RD_BUSY));

    // ---------------- randomised traffic ----------------
    for (int n = 0; n < 80; n++) begin
      logic [7:0]  a;
      logic [31:0] d;
      logic [7:0]  v;
      int          op;
      a  = 8'h40 + 8'($urandom_range(0, 7));
      op = $urandom_range(0, 2);
      if (op == 0) begin
        d = ($urandom_range(0, 1) == 1) ? $urandom : (32'hFFFF_FF00 | 32'($urandom_range(0, 255)));
        host_access(1'b1, 1'b0, a, d, bc, rdv);
        golden[a] = d;
        check("rnd_wr_busy", 32'(bc), 32'(WR_BUSY));
      end else if (op == 1) begin
        host_access(1'b0, 1'b1, a, 32'h0, bc, rdv);
        check("rnd_rd_data", rdv, golden[a]);
        check("rnd_rd_busy", 32'(bc), 32'(RD_BUSY));
      end else begin
        v = 8'($urandom_range(0, 255));
        do_inc(a, v, c0);
        golden[a] = sat_add(golden[a], v);
        repeat (2) tick();
      end
    end

    for (int i = 0; i < 8; i++) begin
      check("final_mem", mem[8'h40 + 8'(i)], golden[8'h40 + 8'(i)]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
